// File: rtl/piso_scan_tx.sv
// Parallel-in/serial-out transmitter for the secure scan link: accepts one WIDTH-bit
// word, waits LEAD_CYCLES, then shifts it out MSB-first with a qualifying valid strobe.
module piso_scan_tx #(
  parameter int WIDTH       = 128,
  parameter int LEAD_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             abort,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int LW = (LEAD_CYCLES > 0) ? $clog2(LEAD_CYCLES + 1) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [LW-1:0] LEAD_INIT = LW'(LEAD_CYCLES);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [LW-1:0]    lead_cnt;
  logic [CW-1:0]    bit_cnt;

  // Load handshake: a word is accepted on any edge where load_valid && load_ready.
  // load_ready is combinational from state, so it is high during reset as well.
  assign load_ready = (state == IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      shreg        <= '0;
      lead_cnt     <= '0;
      bit_cnt      <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (abort && (state == LEAD || state == SHIFT)) begin
      // Cancel discards the partial frame; no done pulse is produced.
      state        <= IDLE;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            shreg    <= data_in;
            lead_cnt <= LEAD_INIT;
            busy     <= 1'b1;
            state    <= LEAD;
          end
        end
        LEAD: begin
          if (lead_cnt == '0) begin
            serial_out   <= shreg[WIDTH-1];
            serial_valid <= 1'b1;
            shreg        <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt      <= CW'(1);
            state        <= SHIFT;
          end else begin
            lead_cnt <= lead_cnt - LW'(1);
          end
        end
        SHIFT: begin
          if (bit_cnt == BIT_LAST) begin
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            done         <= 1'b1;
            state        <= DONE;
          end else begin
            serial_out <= shreg[WIDTH-1];
            shreg      <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt    <= bit_cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/piso_scan_tx.md
# piso_scan_tx

Parallel-in/serial-out transmitter for the secure scan path. Accepts one WIDTH-bit word (typically an encrypted 128-bit scan/test payload) over a valid/ready load handshake. After a programmable lead-in gap, it shifts the word out MSB-first on a single serial wire with a qualifying valid strobe. It is the sending end of the 128-bit serial scan-data link, feeding the die-to-die serial scan chain toward the serial-to-parallel capture block.

## Interface
- WIDTH, 128: payload width in bits; must be >= 2.
- LEAD_CYCLES, 5: idle cycles inserted between load acceptance and the first serial bit; 0 is legal.
- clk  input  1  clock; all logic is on the rising edge.
- reset_n  input  1  reset; asynchronous, active-low.
- data_in  input  WIDTH  payload; sampled only on the accepting edge.
- load_valid  input  1  payload request.
- load_ready  output  1  high exactly while state is IDLE (combinational from state).
- abort  input  1  synchronous cancel of an in-flight frame.
- serial_out  output  1  serial data, registered; 0 whenever serial_valid is 0.
- serial_valid  output  1  registered; high during each of the WIDTH data-bit cycles.
- busy  output  1  registered; high in LEAD, SHIFT and DONE.
- done  output  1  registered; one-cycle pulse after the last bit.

## Operation
- State machine: IDLE, LEAD, SHIFT, DONE.
- Internal registers: WIDTH-bit shift register shreg, lead counter of $clog2(LEAD_CYCLES+1) bits (minimum 1), and bit counter bit_cnt of $clog2(WIDTH+1) bits.
- **IDLE:**
  - On load_valid && load_ready: shreg <= data_in, lead counter <= LEAD_CYCLES, go to LEAD.
  - data_in is ignored at all other times.
- **LEAD:**
  - If lead counter is 0: serial_out <= shreg[WIDTH-1], serial_valid <= 1, shift shreg left by 1, bit_cnt <= 1, go to SHIFT.
  - Otherwise decrement the lead counter.
- **SHIFT:**
  - If bit_cnt == WIDTH: serial_out <= 0, serial_valid <= 0, done <= 1, go to DONE.
  - Otherwise drive the next MSB, shift, and increment bit_cnt.
- **DONE:** done <= 0, go to IDLE.
- **abort:** if high in LEAD or SHIFT, go to IDLE on that edge. serial_valid, serial_out, busy <= 0. done stays 0. The partial frame is discarded. abort in IDLE or DONE has no effect.
- load_valid while not ready is ignored; no queuing.
- Bit order: bit k of the frame (k = 0..WIDTH-1) equals data_in[WIDTH-1-k], i.e. MSB first.

## Timing
- Reset (asynchronous assertion): state IDLE, serial_out 0, serial_valid 0, busy 0, done 0, shreg 0, both counters 0. load_ready is 1 during and after reset.
- Reset asserted mid-frame aborts immediately. No done is generated. The next accept must start a full new frame.
- Let E0 be the accepting edge and L = LEAD_CYCLES.
- busy rises after E0.
- Frame bit k is on serial_out with serial_valid=1 in the cycle after edge E0+L+1+k.
- The last bit follows edge E0+L+WIDTH.
- serial_valid falls and done pulses after edge E0+L+WIDTH+1.
- busy falls and load_ready rises after edge E0+L+WIDTH+2.
- Minimum frame period: L+WIDTH+3 cycles.
- L=0: the first bit follows E0+1 (one cycle in LEAD).
- abort sampled at edge Ea: outputs are cleared after Ea, and load_ready=1 in the following cycle. A new accept is possible at edge Ea+1.
- serial_valid is never high for more than WIDTH consecutive cycles, and has at least L+3 low cycles between frames.

## Test plan
- **Reset values:** assert reset_n=0 mid-SHIFT -> all outputs 0 and load_ready=1 immediately. Release, load 128'h8000_..._0001 -> full frame, first bit 1, bits 1..126 are 0, last bit 1.
- **Baseline frame:** L=5, load 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98 at E0 -> serial_valid high for exactly 128 cycles starting after E0+6. Sampled bits reassemble the word MSB-first. done pulses once after E0+134. load_ready returns after E0+135.
- **Back-to-back:** hold load_valid=1 with two different words -> the second accept occurs at the first edge with load_ready=1. There are exactly L+3 cycles with serial_valid=0 between frames. Both words are reproduced.
- **Busy protection:** change data_in and pulse load_valid during SHIFT -> the frame in flight is unchanged and no extra accept occurs.
- **Abort:** pulse abort at bit 40 -> serial_valid drops the next cycle, done never asserts, and a new load one cycle later transmits a full, correct 128-bit frame.
- **Lead-in edge case:** LEAD_CYCLES=0 and WIDTH=8, load 8'hA5 -> bits 1,0,1,0,0,1,0,1 appear after edges E0+1..E0+8, and done pulses after E0+9.
